pl_header_sync: RTL and testbench

Receive-side physical-layer header synchronizer for the DVS2 modem. It takes the stream of hard-decision 3-bit symbol phase indices and searches for the 90-symbol PL header sequence using a sliding-window mismatch count. It confirms the header at the configured frame spacing, then flywheels through corrupted headers, giving downstream demap/deframe logic a frame-start strobe and a lock flag. It sits between the symbol slicer and the payload deframer.

---
 rtl/pl_header_sync.sv | 171 +++++++++++++++++
 tb/tb_pl_header_sync.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_header_sync.sv
// Purpose: finds the 90-symbol PL header by sliding-window mismatch count, then verifies/flywheels at frame spacing.
// Latency: hdr_hit/frame_sync/mism/state/locked update 2 cycles after the valid cycle carrying header symbol 89.
// Backpressure: none; one symbol per cycle, in_valid may toggle freely.
module pl_header_sync #(
    parameter int THRESH     = 6,
    parameter int CONFIRM    = 2,
    parameter int MISS_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [2:0]  in_sym,
    input  logic [15:0] frame_len,
    output logic        hdr_hit,
    output logic        frame_sync,
    output logic        locked,
    output logic [6:0]  mism,
    output logic [1:0]  state
);

    localparam int HDR_LEN = 90;
    localparam int CW      = $clog2(CONFIRM + 1);
    localparam int MW      = $clog2(MISS_LIMIT + 1);

    localparam logic [6:0]    THR     = 7'(THRESH);
    localparam logic [CW-1:0] CONF_N  = CW'(CONFIRM);
    localparam logic [MW-1:0] MISS_N  = MW'(MISS_LIMIT);

    // One hex digit per header symbol, symbol 0 in the most significant digit.
    localparam logic [359:0] PAT_HEX =
        360'h0536063505_0636353636_0606360506_0636363635_3636350606_3535363636_0535353606_3536353606_0506350536;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } st_t;

    logic [2:0]    win [HDR_LEN];
    logic [6:0]    fill;
    logic          res_vld;
    logic [6:0]    mism_c;
    logic          hit_c;

    st_t           st, st_n;
    logic [15:0]   cnt, cnt_n;
    logic [15:0]   flen, flen_n;
    logic [CW-1:0] conf, conf_n;
    logic [MW-1:0] miss, miss_n;
    logic          hit_n, fs_n;
    logic [6:0]    mism_n;
    logic [15:0]   flen_s;
    logic          due;

    // Window: win[0] holds the oldest symbol, aligned to header symbol 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HDR_LEN; i++) win[i] <= '0;
            fill    <= '0;
            res_vld <= 1'b0;
        end else begin
            res_vld <= in_valid && (fill >= 7'(HDR_LEN - 1));
            if (in_valid) begin
                for (int i = 0; i < HDR_LEN - 1; i++) win[i] <= win[i+1];
                win[HDR_LEN-1] <= in_sym;
                if (fill != 7'(HDR_LEN)) fill <= fill + 7'd1;
            end
        end
    end

    always_comb begin
        mism_c = '0;
        for (int i = 0; i < HDR_LEN; i++)
            mism_c = mism_c + {6'd0, (win[i] != PAT_HEX[358-4*i -: 3])};
    end

    assign hit_c  = (mism_c <= THR);
    assign flen_s = (frame_len < 16'(HDR_LEN)) ? 16'(HDR_LEN) : frame_len;
    assign due    = (({1'b0, cnt} + 17'd1) == {1'b0, flen});

    always_comb begin
        st_n   = st;
        cnt_n  = cnt;
        flen_n = flen;
        conf_n = conf;
        miss_n = miss;
        hit_n  = 1'b0;
        fs_n   = 1'b0;
        mism_n = mism;
        if (res_vld) begin
            unique case (st)
                SEARCH: begin
                    mism_n = mism_c;
                    if (hit_c) begin
                        hit_n  = 1'b1;
                        fs_n   = 1'b1;
                        cnt_n  = '0;
                        flen_n = flen_s;
                        conf_n = '0;
                        st_n   = VERIFY;
                    end
                end
                VERIFY: begin
                    if (due) begin
                        mism_n = mism_c;
                        cnt_n  = '0;
                        flen_n = flen_s;
                        if (hit_c) begin
                            hit_n  = 1'b1;
                            fs_n   = 1'b1;
                            conf_n = conf + 1'b1;
                            if (conf + 1'b1 == CONF_N) begin
                                st_n   = LOCK;
                                miss_n = '0;
                            end
                        end else begin
                            st_n = SEARCH;
                        end
                    end else begin
                        cnt_n = cnt + 16'd1;
                    end
                end
                LOCK: begin
                    if (due) begin
                        mism_n = mism_c;
                        cnt_n  = '0;
                        flen_n = flen_s;
                        fs_n   = 1'b1;
                        if (hit_c) begin
                            hit_n  = 1'b1;
                            miss_n = '0;
                        end else begin
                            miss_n = miss + 1'b1;
                            if (miss + 1'b1 == MISS_N) st_n = SEARCH;
                        end
                    end else begin
                        cnt_n = cnt + 16'd1;
                    end
                end
                default: st_n = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= SEARCH;
            cnt        <= '0;
            flen       <= 16'(HDR_LEN);
            conf       <= '0;
            miss       <= '0;
            hdr_hit    <= 1'b0;
            frame_sync <= 1'b0;
            locked     <= 1'b0;
            mism       <= '0;
        end else begin
            st         <= st_n;
            cnt        <= cnt_n;
            flen       <= flen_n;
            conf       <= conf_n;
            miss       <= miss_n;
            hdr_hit    <= hit_n;
            frame_sync <= fs_n;
            locked     <= (st_n == LOCK);
            mism       <= mism_n;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_pl_header_sync.sv
// Bench for pl_header_sync: directed header streams checked every cycle against a symbol-level model.
module tb_pl_header_sync;

    localparam int THRESH     = 6;
    localparam int CONFIRM    = 2;
    localparam int MISS_LIMIT = 3;
    localparam logic [359:0] PAT_HEX =
        360'h0536063505_0636353636_0606360506_0636363635_3636350606_3535363636_0535353606_3536353606_0506350536;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_sym = 3'd0;
    logic [15:0] frame_len = 16'd200;
    logic        hdr_hit, frame_sync, locked;
    logic [6:0]  mism;
    logic [1:0]  state;

    pl_header_sync #(.THRESH(THRESH), .CONFIRM(CONFIRM), .MISS_LIMIT(MISS_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym), .frame_len(frame_len),
        .hdr_hit(hdr_hit), .frame_sync(frame_sync), .locked(locked), .mism(mism), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit hit;
        bit fs;
        int mism;
        int st;
        bit lk;
    } ev_t;

    int   errs = 0;
    int   nchk = 0;
    int   cyc  = 0;
    int   hit_cnt = 0;
    bit   gappy = 0;
    logic [2:0] pat [90];
    ev_t  evq [$];

    // Model: symbol history plus anchor expressed as a result index.
    logic [2:0] hist [$];
    int   nsym, rcount, m_st, m_anchor, m_flen, m_conf, m_miss;

    bit   e_hit, e_fs, e_lk;
    int   e_mism, e_st;
    ev_t  ev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        e_hit = 0;
        e_fs  = 0;
        if (!rst_n) begin
            e_mism = 0; e_st = 0; e_lk = 0;
        end else begin
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                ev = evq.pop_front();
                if (ev.cyc == cyc) begin
                    e_hit = ev.hit; e_fs = ev.fs; e_mism = ev.mism; e_st = ev.st; e_lk = ev.lk;
                end
            end
        end
        chk("hdr_hit", int'(hdr_hit), int'(e_hit));
        chk("frame_sync", int'(frame_sync), int'(e_fs));
        chk("locked", int'(locked), int'(e_lk));
        chk("mism", int'(mism), e_mism);
        chk("state", int'(state), e_st);
        if (hdr_hit) hit_cnt++;
    end

    task automatic model_clear();
        hist.delete();
        evq.delete();
        nsym = 0; rcount = 0; m_st = 0; m_anchor = 0; m_flen = 90; m_conf = 0; m_miss = 0;
    endtask

    task automatic model_push(input logic [2:0] s);
        int  mm;
        bit  hit;
        ev_t e;
        hist.push_back(s);
        if (hist.size() > 90) hist.delete(0);
        nsym++;
        if (nsym < 90) return;
        mm = 0;
        for (int i = 0; i < 90; i++) if (hist[i] != pat[i]) mm++;
        rcount++;
        hit = (mm <= THRESH);
        if (m_st != 0 && (rcount - m_anchor) != m_flen) return;
        e.cyc = cyc + 2; e.mism = mm; e.hit = 0; e.fs = 0;
        case (m_st)
            0: if (hit) begin e.hit = 1; e.fs = 1; m_conf = 0; m_st = 1; end
            1: if (hit) begin
                   e.hit = 1; e.fs = 1; m_conf++;
                   if (m_conf == CONFIRM) begin m_st = 2; m_miss = 0; end
               end else m_st = 0;
            default: begin
                e.fs = 1;
                if (hit) begin e.hit = 1; m_miss = 0; end
                else begin m_miss++; if (m_miss == MISS_LIMIT) m_st = 0; end
            end
        endcase
        m_anchor = rcount;
        m_flen = (frame_len < 16'd90) ? 90 : int'(frame_len);
        e.st = m_st; e.lk = (m_st == 2);
        evq.push_back(e);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sym = 3'($urandom_range(0, 7));
    endtask

    task automatic send_sym(input logic [2:0] s);
        if (gappy) while ($urandom_range(0, 1) == 0) idle_cycle();
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_sym = s;
        model_push(s);
    endtask

    task automatic hdr(input int ncorr);
        for (int i = 0; i < 90; i++) send_sym((i < ncorr) ? 3'd7 : pat[i]);
    endtask

    task automatic pad(input int n);
        repeat (n) send_sym(3'd7);
    endtask

    task automatic frame(input int ncorr);
        hdr(ncorr);
        pad(110);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        model_clear();
        #1;
        chk("rst_hdr_hit", int'(hdr_hit), 0);
        chk("rst_frame_sync", int'(frame_sync), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_mism", int'(mism), 0);
        chk("rst_state", int'(state), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [359:0] ph;
        int h0;
        ph = PAT_HEX;
        for (int i = 0; i < 90; i++) pat[i] = ph[358-4*i -: 3];
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("init_state", int'(state), 0);
        chk("init_locked", int'(locked), 0);

        // Clean acquisition, flywheel and lock loss at 200-symbol spacing.
        frame_len = 16'd200;
        hdr(0); pad(2); @(negedge clk);
        chk("acq1_hit", int'(hdr_hit), 1);
        chk("acq1_state", int'(state), 1);
        chk("acq1_mism", int'(mism), 0);
        pad(108);
        hdr(0); pad(2); @(negedge clk);
        chk("acq2_state", int'(state), 1);
        pad(108);
        hdr(0); pad(2); @(negedge clk);
        chk("acq3_locked", int'(locked), 1);
        chk("acq3_state", int'(state), 2);
        pad(108);
        hdr(90); pad(2); @(negedge clk);
        chk("fly1_fs", int'(frame_sync), 1);
        chk("fly1_hit", int'(hdr_hit), 0);
        chk("fly1_mism", int'(mism), 90);
        chk("fly1_locked", int'(locked), 1);
        pad(108);
        frame(90);
        hdr(0); pad(2); @(negedge clk);
        chk("fly_recover_hit", int'(hdr_hit), 1);
        pad(108);
        frame(90);
        frame(90);
        hdr(90); pad(2); @(negedge clk);
        chk("drop_fs", int'(frame_sync), 1);
        chk("drop_locked", int'(locked), 0);
        chk("drop_state", int'(state), 0);
        pad(108);

        // Threshold boundary: 7 corrupted symbols rejected, 6 accepted.
        pad(100);
        hdr(7); pad(2); @(negedge clk);
        chk("thr7_hit", int'(hdr_hit), 0);
        chk("thr7_mism", int'(mism), 7);
        chk("thr7_state", int'(state), 0);
        pad(108);
        hdr(6); pad(2); @(negedge clk);
        chk("thr6_hit", int'(hdr_hit), 1);
        chk("thr6_mism", int'(mism), 6);
        chk("thr6_state", int'(state), 1);
        pad(108);
        pad(200);

        // Verify failure: second header arrives 10 symbols late.
        hdr(0); pad(2); @(negedge clk);
        chk("vf1_state", int'(state), 1);
        pad(118);
        hdr(0); pad(2); @(negedge clk);
        chk("vf_late_hit", int'(hdr_hit), 1);
        chk("vf_late_state", int'(state), 1);
        pad(108);

        // Reset mid-header; window left zeroed must not be evaluated before 90 new symbols.
        for (int i = 0; i < 45; i++) send_sym(pat[i]);
        do_reset();
        for (int i = 1; i < 90; i++) send_sym(pat[i]);
        pad(2); @(negedge clk);
        chk("fill_block_hit", int'(hdr_hit), 0);
        pad(50);

        // Short frame_len is clamped to 90: back-to-back headers lock.
        do_reset();
        frame_len = 16'd50;
        hdr(0); hdr(0); hdr(0); pad(2); @(negedge clk);
        chk("short_locked", int'(locked), 1);
        pad(10);

        // Gappy input.
        do_reset();
        frame_len = 16'd200;
        gappy = 1;
        frame(0); frame(0); frame(0); frame(0);
        gappy = 0;
        @(negedge clk);
        chk("gappy_locked", int'(locked), 1);

        // False-lock check on random symbols.
        do_reset();
        h0 = hit_cnt;
        repeat (1000) send_sym(3'($urandom_range(0, 7)));
        pad(2); @(negedge clk);
        chk("random_hits", hit_cnt - h0, 0);
        chk("random_state", int'(state), 0);

        repeat (5) idle_cycle();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
